// File: rtl/inst_mem_pkg.sv
// Shared widths, types and constants for the instruction-memory responder.
package inst_mem_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned BYTE_W = 8;

  typedef logic [INST_W-1:0] inst_t;

  // Word returned for fetches beyond the end of the array.
  localparam inst_t OOR_INST = 32'h0000_0000;

endpackage

// File: rtl/inst_mem_if.sv
// Fetch interface between the IF stage (master) and the instruction memory (slave).
interface inst_mem_if;
  import inst_mem_pkg::*;

  logic                valid_addr;
  logic [ADDR_W-1:0]   addr;
  logic                valid_inst;
  inst_t               inst;
  logic                busy;

  modport master (
    output valid_addr,
    output addr,
    input  valid_inst,
    input  inst,
    input  busy
  );

  modport slave (
    input  valid_addr,
    input  addr,
    output valid_inst,
    output inst,
    output busy
  );

endinterface

// File: rtl/inst_mem_pipe.sv
// Fixed-latency delay line of {valid, word}. Stage LATENCY-1 is the registered output.
module inst_mem_pipe
  import inst_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 10
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_valid,
  input  inst_t i_data,
  output logic  o_valid,
  output inst_t o_data,
  output logic  o_any_valid
);

  logic [LATENCY-1:0] valid_q;
  inst_t              data_q [LATENCY];

  // Shift valid and data one stage per cycle; data is zeroed on entry when invalid so
  // every stage holds 0 whenever its valid bit is clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= i_valid;
      data_q[0]  <= i_valid ? i_data : '0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  // Output stage and in-flight indication come straight from registers.
  always_comb begin
    o_valid     = valid_q[LATENCY-1];
    o_data      = data_q[LATENCY-1];
    o_any_valid = |valid_q;
  end

endmodule

// File: rtl/inst_mem.sv
// Instruction memory: byte array with a load port, word fetch with fixed response latency.
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int unsigned LATENCY     = 10,
  parameter int unsigned DEPTH_BYTES = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  inst_mem_if.slave         fetch,
  input  logic              i_load_valid,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [BYTE_W-1:0] i_load_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);

  logic [BYTE_W-1:0] mem [DEPTH_BYTES];

  logic [IDX_W-1:0]   load_idx;
  logic               load_in_range;
  logic [IDX_W-3:0]   word_idx;
  logic               fetch_in_range;
  inst_t              rd_word;
  inst_t              fetch_word;
  logic               unused_addr_lsbs;

  // Address decode: range checks on the high bits, alignment by dropping addr[1:0].
  always_comb begin
    load_idx         = i_load_addr[IDX_W-1:0];
    load_in_range    = (i_load_addr[ADDR_W-1:IDX_W] == '0);
    word_idx         = fetch.addr[IDX_W-1:2];
    fetch_in_range   = (fetch.addr[ADDR_W-1:IDX_W] == '0);
    unused_addr_lsbs = ^fetch.addr[1:0];
    rd_word          = {mem[{word_idx, 2'b11}], mem[{word_idx, 2'b10}],
                        mem[{word_idx, 2'b01}], mem[{word_idx, 2'b00}]};
    fetch_word       = fetch_in_range ? rd_word : OOR_INST;
  end

  // Byte load port; contents are deliberately not reset so a loaded program survives.
  // The fetch path reads the array combinationally at the same edge, so a same-edge
  // fetch sees the pre-write byte.
  always_ff @(posedge i_clk) begin
    if (i_load_valid && load_in_range) begin
      mem[load_idx] <= i_load_data;
    end
  end

  inst_mem_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (fetch.valid_addr),
    .i_data      (fetch_word),
    .o_valid     (fetch.valid_inst),
    .o_data      (fetch.inst),
    .o_any_valid (fetch.busy)
  );

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem: LATENCY=10 and LATENCY=1 instances side by side.
module tb_inst_mem;

  localparam int DEPTH = 4096;

  typedef struct {
    logic [31:0] word;
    int          due;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [63:0] load_addr = '0;
  logic [7:0]  load_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] model [DEPTH];
  exp_t q10[$];
  exp_t q1[$];

  inst_mem_if f10 ();
  inst_mem_if f1 ();

  inst_mem #(.LATENCY(10), .DEPTH_BYTES(DEPTH)) u_dut10 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .fetch        (f10),
    .i_load_valid (load_valid),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data)
  );

  inst_mem #(.LATENCY(1), .DEPTH_BYTES(DEPTH)) u_dut1 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .fetch        (f1),
    .i_load_valid (load_valid),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [63:0] a);
    int idx;
    if (a >= 64'(DEPTH)) return 32'h0;
    idx = int'({a[11:2], 2'b00});
    return {model[idx+3], model[idx+2], model[idx+1], model[idx]};
  endfunction

  // Push expectations for strobes set up for the coming edge, apply loads to the model
  // after the reads (read-before-write), advance one edge and clear the strobes.
  task automatic cycle();
    exp_t e;
    if (f10.valid_addr) begin
      e.word = model_word(f10.addr); e.due = cyc + 10; e.acc = cyc + 1;
      q10.push_back(e);
    end
    if (f1.valid_addr) begin
      e.word = model_word(f1.addr); e.due = cyc + 1; e.acc = cyc + 1;
      q1.push_back(e);
    end
    if (load_valid && load_addr < 64'(DEPTH)) model[int'(load_addr[11:0])] = load_data;
    @(posedge clk);
    #2;
    f10.valid_addr = 1'b0;
    f1.valid_addr  = 1'b0;
    load_valid     = 1'b0;
  endtask

  task automatic load_byte(input logic [63:0] a, input logic [7:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    cycle();
  endtask

  // Scoreboards: a response must appear exactly at its due cycle and nowhere else.
  always @(negedge clk) begin
    if (rst_n) begin
      logic busy_exp;
      exp_t e;
      busy_exp = 1'b0;
      foreach (q10[i]) if (q10[i].acc <= cyc) busy_exp = 1'b1;
      check("busy10", 64'(f10.busy), 64'(busy_exp));
      if (q10.size() > 0 && q10[0].due == cyc) begin
        e = q10.pop_front();
        check("valid10", 64'(f10.valid_inst), 64'd1);
        check("inst10", 64'(f10.inst), 64'(e.word));
      end else begin
        check("idle_valid10", 64'(f10.valid_inst), 64'd0);
        check("idle_inst10", 64'(f10.inst), 64'd0);
      end

      busy_exp = 1'b0;
      foreach (q1[i]) if (q1[i].acc <= cyc) busy_exp = 1'b1;
      check("busy1", 64'(f1.busy), 64'(busy_exp));
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        check("valid1", 64'(f1.valid_inst), 64'd1);
        check("inst1", 64'(f1.inst), 64'(e.word));
      end else begin
        check("idle_valid1", 64'(f1.valid_inst), 64'd0);
        check("idle_inst1", 64'(f1.inst), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog [8];
    prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'hA0; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h05; prog[6] = 8'h10; prog[7] = 8'h00;

    f10.valid_addr = 1'b0; f10.addr = '0;
    f1.valid_addr  = 1'b0; f1.addr  = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

    // Reset state.
    repeat (3) begin @(posedge clk); #2; end
    check("rst_valid10", 64'(f10.valid_inst), 64'd0);
    check("rst_inst10", 64'(f10.inst), 64'd0);
    check("rst_busy10", 64'(f10.busy), 64'd0);
    check("rst_valid1", 64'(f1.valid_inst), 64'd0);
    rst_n = 1'b1;

    // Preload 0..31; loads work during reset-release and survive later resets.
    for (int i = 0; i < 32; i++) begin
      load_byte(64'(i), (i < 8) ? prog[i] : 8'(i * 17 + 1));
    end

    // Out-of-range load must be dropped, not alias onto byte 8.
    load_byte(64'(DEPTH + 8), 8'h5A);

    // Single fetch, then back-to-back, misaligned, out-of-range and aliased address.
    f10.valid_addr = 1'b1; f10.addr = 64'd0; cycle();
    repeat (12) cycle();
    f10.valid_addr = 1'b1; f10.addr = 64'd0; cycle();
    f10.valid_addr = 1'b1; f10.addr = 64'd4; cycle();
    f10.valid_addr = 1'b1; f10.addr = 64'd6; cycle();
    f10.valid_addr = 1'b1; f10.addr = 64'(DEPTH); cycle();
    f10.valid_addr = 1'b1; f10.addr = 64'd8; cycle();
    f10.valid_addr = 1'b1; f10.addr = 64'hFFFF_FFFF_FFFF_FFFC; cycle();
    repeat (12) cycle();

    // Same-edge load and fetch: old byte, then new byte on the next fetch.
    f10.valid_addr = 1'b1; f10.addr = 64'd0;
    load_valid = 1'b1; load_addr = 64'd0; load_data = 8'hFF;
    cycle();
    f10.valid_addr = 1'b1; f10.addr = 64'd0; cycle();
    load_byte(64'd0, 8'h13);
    repeat (12) cycle();

    // Three requests in flight, then a half-cycle reset pulse discards them.
    f10.valid_addr = 1'b1; f10.addr = 64'd0; cycle();
    f10.valid_addr = 1'b1; f10.addr = 64'd4; cycle();
    f10.valid_addr = 1'b1; f10.addr = 64'd8; cycle();
    cycle();
    rst_n = 1'b0;
    q10.delete();
    q1.delete();
    #1;
    check("pulse_valid10", 64'(f10.valid_inst), 64'd0);
    check("pulse_inst10", 64'(f10.inst), 64'd0);
    check("pulse_busy10", 64'(f10.busy), 64'd0);
    #4;
    rst_n = 1'b1;
    @(posedge clk); #2;
    repeat (12) cycle();
    f10.valid_addr = 1'b1; f10.addr = 64'd0; cycle();
    repeat (12) cycle();

    // LATENCY=1 instance: request every cycle, responses every cycle in order.
    for (int i = 0; i < 8; i++) begin
      f1.valid_addr = 1'b1; f1.addr = 64'(i * 4); cycle();
    end
    f1.valid_addr = 1'b1; f1.addr = 64'(DEPTH + 4); cycle();
    repeat (4) cycle();

    check("drain10", 64'(q10.size()), 64'd0);
    check("drain1", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
